// File: rtl/user_pulse_seq_pkg.sv
// ----------------------------------------------------------------------------
// user_pulse_seq_pkg
// Shared types for the programmable pulse sequencer:
//   ch_state_e     channel FSM state encoding (IDLE/HIGH/LOW/DONE)
//   REG_*          word offsets (addr[5:2]) inside a channel page
//   phase_t        one phase table entry {high_len, low_len}
//   ups_obi_req_t  default OBI request struct (subset used by this block)
//   ups_obi_rsp_t  default OBI response struct
//   len_to_cnt     converts a phase length into a down-counter preload
// ----------------------------------------------------------------------------
package user_pulse_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } ch_state_e;

    // Register word indices, i.e. byte offset >> 2.
    localparam logic [3:0] REG_CMD    = 4'd0;
    localparam logic [3:0] REG_CTRL   = 4'd1;
    localparam logic [3:0] REG_STATUS = 4'd2;
    localparam logic [3:0] REG_PH_IDX = 4'd3;
    localparam logic [3:0] REG_PH_DAT = 4'd4;
    localparam logic [3:0] REG_NPH    = 4'd5;
    localparam logic [3:0] REG_IRQ_EN = 4'd6;

    // Table fields are stored at the maximum supported width; bits above
    // CNT_W are always written as zero.
    typedef struct packed {
        logic [15:0] high_len;
        logic [15:0] low_len;
    } phase_t;

    localparam int unsigned OBI_ID_W = 1;

    typedef struct packed {
        logic                req;
        logic                we;
        logic [3:0]          be;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic [OBI_ID_W-1:0] aid;
    } ups_obi_req_t;

    typedef struct packed {
        logic                gnt;
        logic                rvalid;
        logic [31:0]         rdata;
        logic [OBI_ID_W-1:0] rid;
        logic                err;
    } ups_obi_rsp_t;

    // A phase lasts max(len,1) cycles; the counter counts down to zero,
    // so the preload is max(len,1)-1.
    function automatic logic [15:0] len_to_cnt(input logic [15:0] len);
        return (len == 16'd0) ? 16'd0 : (len - 16'd1);
    endfunction

endpackage

// File: rtl/user_pulse_seq_ch.sv
// ----------------------------------------------------------------------------
// user_pulse_seq_ch
// One sequencer channel: FSM, phase/loop counters, DEPTH-entry phase table,
// per-channel registers and the registered pulse output.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   start_i, stop_i      one-cycle commands (stop has priority)
//   *_we_i               register write strobes, already qualified by the
//                        top (no CTRL/PH_DAT/NPH strobe arrives while busy)
//   wdata_i              bus write data
//   ctrl_o .. nph_o      register read values
//   busy_o, done_o       channel running / done_sticky
//   pulse_o              registered pad output
//   state_o              current FSM state (debug)
// ----------------------------------------------------------------------------
module user_pulse_seq_ch
    import user_pulse_seq_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned LOOP_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        ctrl_we_i,
    input  logic        status_we_i,
    input  logic        ph_idx_we_i,
    input  logic        ph_dat_we_i,
    input  logic        nph_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ctrl_o,
    output logic [31:0] status_o,
    output logic [31:0] ph_idx_o,
    output logic [31:0] ph_dat_o,
    output logic [31:0] nph_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pulse_o,
    output ch_state_e   state_o
);

    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned NPH_W  = PW + 1;

    ch_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     ph_q, ph_d;
    logic [LOOP_W-1:0] loops_rem_q, loops_rem_d;
    logic              done_q, done_d;
    logic              pulse_q, pulse_d;
    logic              invert_q, invert_d;
    logic              idle_lvl_q, idle_lvl_d;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic [PW-1:0]     ph_idx_q, ph_idx_d;
    logic [NPH_W-1:0]  nph_q, nph_d;
    phase_t            tbl_q [DEPTH];
    phase_t            tbl_d [DEPTH];

    logic              busy;
    logic              last_ph;
    logic [PW-1:0]     nxt_ph;
    logic              unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        loops_rem_d = loops_rem_q;
        done_d      = done_q;
        invert_d    = invert_q;
        idle_lvl_d  = idle_lvl_q;
        loops_d     = loops_q;
        ph_idx_d    = ph_idx_q;
        nph_d       = nph_q;
        tbl_d       = tbl_q;

        busy    = (state_q == HIGH) || (state_q == LOW);
        nxt_ph  = ph_q + PW'(1);
        last_ph = ({1'b0, ph_q} + NPH_W'(1)) >= nph_q;
        pulse_d = busy ? ((state_q == HIGH) ^ invert_q) : idle_lvl_q;

        // Register writes
        if (ctrl_we_i) begin
            invert_d   = wdata_i[0];
            idle_lvl_d = wdata_i[1];
            loops_d    = wdata_i[8 +: LOOP_W];
        end
        if (ph_idx_we_i) begin
            ph_idx_d = wdata_i[PW-1:0];
        end
        if (ph_dat_we_i) begin
            tbl_d[ph_idx_q].high_len = 16'(wdata_i[CNT_W-1:0]);
            tbl_d[ph_idx_q].low_len  = 16'(wdata_i[16 +: CNT_W]);
            ph_idx_d                 = ph_idx_q + PW'(1);
        end
        if (nph_we_i) begin
            if (wdata_i == 32'd0) begin
                nph_d = NPH_W'(1);
            end else if (wdata_i > 32'(DEPTH)) begin
                nph_d = NPH_W'(DEPTH);
            end else begin
                nph_d = wdata_i[NPH_W-1:0];
            end
        end
        // W1C is applied before the FSM so a same-cycle set overrides it.
        if (status_we_i && wdata_i[3]) begin
            done_d = 1'b0;
        end

        if (stop_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_d     = HIGH;
                        ph_d        = '0;
                        loops_rem_d = loops_q;
                        cnt_d       = CNT_W'(len_to_cnt(tbl_q[0].high_len));
                    end
                end
                HIGH: begin
                    if (cnt_q == '0) begin
                        state_d = LOW;
                        cnt_d   = CNT_W'(len_to_cnt(tbl_q[ph_q].low_len));
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                LOW: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!last_ph) begin
                        state_d = HIGH;
                        ph_d    = nxt_ph;
                        cnt_d   = CNT_W'(len_to_cnt(tbl_q[nxt_ph].high_len));
                    end else if ((loops_q == '0) || (loops_rem_q > LOOP_W'(1))) begin
                        // loops==0 repeats forever without touching loops_rem.
                        if (loops_q != '0) begin
                            loops_rem_d = loops_rem_q - LOOP_W'(1);
                        end
                        state_d = HIGH;
                        ph_d    = '0;
                        cnt_d   = CNT_W'(len_to_cnt(tbl_q[0].high_len));
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ph_q        <= '0;
            loops_rem_q <= '0;
            done_q      <= 1'b0;
            pulse_q     <= 1'b0;
            invert_q    <= 1'b0;
            idle_lvl_q  <= 1'b0;
            loops_q     <= '0;
            ph_idx_q    <= '0;
            nph_q       <= NPH_W'(1);
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            loops_rem_q <= loops_rem_d;
            done_q      <= done_d;
            pulse_q     <= pulse_d;
            invert_q    <= invert_d;
            idle_lvl_q  <= idle_lvl_d;
            loops_q     <= loops_d;
            ph_idx_q    <= ph_idx_d;
            nph_q       <= nph_d;
            tbl_q       <= tbl_d;
        end
    end

    always_comb begin
        ctrl_o                   = '0;
        ctrl_o[0]                = invert_q;
        ctrl_o[1]                = idle_lvl_q;
        ctrl_o[8 +: LOOP_W]      = loops_q;
        status_o                 = '0;
        status_o[1:0]            = state_q;
        status_o[2]              = busy;
        status_o[3]              = done_q;
        status_o[8 +: LOOP_W]    = loops_rem_q;
        status_o[16 +: PW]       = ph_q;
    end

    assign ph_idx_o = 32'(ph_idx_q);
    assign ph_dat_o = {tbl_q[ph_idx_q].low_len, tbl_q[ph_idx_q].high_len};
    assign nph_o    = 32'(nph_q);
    assign busy_o   = busy;
    assign done_o   = done_q;
    assign pulse_o  = pulse_q;
    assign state_o  = state_q;

endmodule

// File: rtl/user_pulse_seq.sv
// ----------------------------------------------------------------------------
// user_pulse_seq
// Multi-channel programmable pulse sequencer on an OBI slave port.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous reset, active-low
//   obi_req_i  OBI request (gnt is returned combinationally)
//   obi_rsp_o  OBI response; rvalid/rid/rdata/err one cycle after the grant
//   pulse_o    registered pulse outputs, one per channel
//   irq_o      level interrupt = |(done_sticky & irq_en)
// Handshake: every request is granted in the cycle it is presented; its
// response is valid exactly one cycle later, with no backpressure.
// Address decode: addr[6+:CH_W] = channel page, addr[5:2] = register.
// ----------------------------------------------------------------------------
module user_pulse_seq
    import user_pulse_seq_pkg::*;
#(
    parameter type         obi_req_t = user_pulse_seq_pkg::ups_obi_req_t,
    parameter type         obi_rsp_t = user_pulse_seq_pkg::ups_obi_rsp_t,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned LOOP_W    = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  obi_req_t        obi_req_i,
    output obi_rsp_t        obi_rsp_o,
    output logic [N_CH-1:0] pulse_o,
    output logic            irq_o
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [CH_W-1:0]     ch_sel;
    logic [3:0]          reg_sel;
    logic [N_CH-1:0]     ch_hit;
    logic                ch_ok;
    logic                sel_busy;
    logic [31:0]         sel_ctrl, sel_status, sel_ph_idx, sel_ph_dat, sel_nph;

    logic [N_CH-1:0]     irq_en_q, irq_en_d;
    logic                rvalid_q, rvalid_d;
    logic [OBI_ID_W-1:0] rid_q, rid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                cmd_we;
    logic                ctrl_we, status_we, ph_idx_we, ph_dat_we, nph_we;
    logic [N_CH-1:0]     start_vec, stop_vec, busy_vec, done_vec;
    logic [31:0]         ctrl_rd   [N_CH];
    logic [31:0]         status_rd [N_CH];
    logic [31:0]         ph_idx_rd [N_CH];
    logic [31:0]         ph_dat_rd [N_CH];
    logic [31:0]         nph_rd    [N_CH];
    ch_state_e           state_dbg [N_CH];
    logic                unused_bits;

    assign ch_sel      = obi_req_i.addr[6 +: CH_W];
    assign reg_sel     = obi_req_i.addr[5:2];
    assign unused_bits = ^{obi_req_i.be, obi_req_i.addr[31:6+CH_W], obi_req_i.addr[1:0]};

    // Channel select and read mux; an out-of-range page hits no channel.
    always_comb begin
        sel_busy   = 1'b0;
        sel_ctrl   = '0;
        sel_status = '0;
        sel_ph_idx = '0;
        sel_ph_dat = '0;
        sel_nph    = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_hit[i] = (ch_sel == CH_W'(i));
            if (ch_hit[i]) begin
                sel_busy   = busy_vec[i];
                sel_ctrl   = ctrl_rd[i];
                sel_status = status_rd[i];
                sel_ph_idx = ph_idx_rd[i];
                sel_ph_dat = ph_dat_rd[i];
                sel_nph    = nph_rd[i];
            end
        end
        ch_ok = |ch_hit;
    end

    // Register access decode. Rejected accesses return err with no effect.
    always_comb begin
        irq_en_d  = irq_en_q;
        rvalid_d  = obi_req_i.req;
        rid_d     = obi_req_i.aid;
        rdata_d   = '0;
        err_d     = 1'b0;
        cmd_we    = 1'b0;
        ctrl_we   = 1'b0;
        status_we = 1'b0;
        ph_idx_we = 1'b0;
        ph_dat_we = 1'b0;
        nph_we    = 1'b0;
        if (obi_req_i.req) begin
            if (!ch_ok) begin
                err_d = 1'b1;
            end else begin
                case (reg_sel)
                    REG_CMD: cmd_we = obi_req_i.we;
                    REG_CTRL: begin
                        if (!obi_req_i.we)  rdata_d = sel_ctrl;
                        else if (sel_busy)  err_d   = 1'b1;
                        else                ctrl_we = 1'b1;
                    end
                    REG_STATUS: begin
                        if (obi_req_i.we) status_we = 1'b1;
                        else              rdata_d   = sel_status;
                    end
                    REG_PH_IDX: begin
                        if (obi_req_i.we) ph_idx_we = 1'b1;
                        else              rdata_d   = sel_ph_idx;
                    end
                    REG_PH_DAT: begin
                        if (!obi_req_i.we)  rdata_d   = sel_ph_dat;
                        else if (sel_busy)  err_d     = 1'b1;
                        else                ph_dat_we = 1'b1;
                    end
                    REG_NPH: begin
                        if (!obi_req_i.we)  rdata_d = sel_nph;
                        else if (sel_busy)  err_d   = 1'b1;
                        else                nph_we  = 1'b1;
                    end
                    REG_IRQ_EN: begin
                        if (obi_req_i.we) irq_en_d = obi_req_i.wdata[N_CH-1:0];
                        else              rdata_d  = 32'(irq_en_q);
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    assign start_vec = cmd_we ? obi_req_i.wdata[N_CH-1:0]   : '0;
    assign stop_vec  = cmd_we ? obi_req_i.wdata[16 +: N_CH] : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_en_q <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        user_pulse_seq_ch #(
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W),
            .LOOP_W (LOOP_W)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .start_i     (start_vec[g]),
            .stop_i      (stop_vec[g]),
            .ctrl_we_i   (ctrl_we   & ch_hit[g]),
            .status_we_i (status_we & ch_hit[g]),
            .ph_idx_we_i (ph_idx_we & ch_hit[g]),
            .ph_dat_we_i (ph_dat_we & ch_hit[g]),
            .nph_we_i    (nph_we    & ch_hit[g]),
            .wdata_i     (obi_req_i.wdata),
            .ctrl_o      (ctrl_rd[g]),
            .status_o    (status_rd[g]),
            .ph_idx_o    (ph_idx_rd[g]),
            .ph_dat_o    (ph_dat_rd[g]),
            .nph_o       (nph_rd[g]),
            .busy_o      (busy_vec[g]),
            .done_o      (done_vec[g]),
            .pulse_o     (pulse_o[g]),
            .state_o     (state_dbg[g])
        );
    end

    assign irq_o = |(done_vec & irq_en_q);

    always_comb begin
        obi_rsp_o        = '0;
        obi_rsp_o.gnt    = obi_req_i.req;
        obi_rsp_o.rvalid = rvalid_q;
        obi_rsp_o.rid    = rid_q;
        obi_rsp_o.rdata  = rdata_q;
        obi_rsp_o.err    = err_q;
    end

endmodule

// File: tb/tb_user_pulse_seq.sv
module tb_user_pulse_seq;
    import user_pulse_seq_pkg::*;

    localparam int N_CH  = 4;
    localparam int DEPTH = 8;

    logic            clk;
    logic            rst_n;
    ups_obi_req_t    req;
    ups_obi_rsp_t    rsp;
    logic [N_CH-1:0] pulse;
    logic            irq;

    int n_checks;
    int n_fail;

    // {irq, pulse[3:0]} expected per sampled cycle, and expected read data.
    logic [4:0]  exp_q[$];
    logic [31:0] rd_exp_q[$];
    logic [OBI_ID_W-1:0] aid;

    user_pulse_seq #(
        .N_CH   (N_CH),
        .DEPTH  (DEPTH),
        .CNT_W  (16),
        .LOOP_W (8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .pulse_o   (pulse),
        .irq_o     (irq)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ra(input int ch, input logic [3:0] r);
        return (32'(ch) << 6) | (32'(r) << 2);
    endfunction

    // ---------------- drivers ----------------
    task automatic bus_write(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic exp_err);
        req       = '0;
        req.req   = 1'b1;
        req.we    = 1'b1;
        req.be    = 4'hf;
        req.addr  = addr;
        req.wdata = data;
        req.aid   = aid;
        #1;
        check_eq({tag, "_gnt"}, 32'(rsp.gnt), 32'd1);
        @(negedge clk);
        req = '0;
        check_eq({tag, "_rvalid"}, 32'(rsp.rvalid), 32'd1);
        check_eq({tag, "_err"}, 32'(rsp.err), 32'(exp_err));
        check_eq({tag, "_rid"}, 32'(rsp.rid), 32'(aid));
        aid = ~aid;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        rd_exp_q.push_back(exp_data);
        req      = '0;
        req.req  = 1'b1;
        req.addr = addr;
        req.aid  = aid;
        @(negedge clk);
        req = '0;
        check_eq({tag, "_rvalid"}, 32'(rsp.rvalid), 32'd1);
        check_eq({tag, "_err"}, 32'(rsp.err), 32'(exp_err));
        check_eq({tag, "_rdata"}, rsp.rdata,
                 (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : 32'hxxxx_xxxx);
        aid = ~aid;
    endtask

    task automatic play(input string tag, input int n, input logic [4:0] mask);
        logic [4:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bxxxxx;
            check_eq($sformatf("%s_%0d", tag, i + 1), 32'({irq, pulse} & mask), 32'(e));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lens[4];
        logic vals[4];
        int k;
        n_checks = 0;
        n_fail   = 0;
        aid      = '0;
        req      = '0;
        rst_n    = 1'b0;
        lens = '{3, 2, 1, 4};
        vals = '{1'b1, 1'b0, 1'b1, 1'b0};
        idle(3);
        check_eq("rst_pulse", 32'(pulse), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_rvalid", 32'(rsp.rvalid), 32'd0);
        rst_n = 1'b1;
        idle(1);
        bus_read("rst_status0", ra(0, REG_STATUS), 32'd0, 1'b0);
        bus_read("rst_nph0", ra(0, REG_NPH), 32'd1, 1'b0);

        // ---- test 1/2: two-phase table, two loops, IRQ ----
        bus_write("t1_idx", ra(0, REG_PH_IDX), 32'd0, 1'b0);
        bus_write("t1_dat0", ra(0, REG_PH_DAT), 32'h0002_0003, 1'b0);
        bus_write("t1_dat1", ra(0, REG_PH_DAT), 32'h0004_0001, 1'b0);
        bus_write("t1_nph", ra(0, REG_NPH), 32'd2, 1'b0);
        bus_write("t1_ctrl", ra(0, REG_CTRL), 32'h0000_0200, 1'b0);
        bus_write("t1_irqen", ra(0, REG_IRQ_EN), 32'h1, 1'b0);
        bus_read("t1_idx_rd", ra(0, REG_PH_IDX), 32'd2, 1'b0);
        k = 0;
        for (int l = 0; l < 2; l++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < lens[s]; c++) begin
                    k++;
                    exp_q.push_back({(k >= 20), 3'b000, vals[s]});
                end
            end
        end
        exp_q.push_back(5'b10000);
        exp_q.push_back(5'b10000);
        bus_write("t1_start", ra(0, REG_CMD), 32'h1, 1'b0);
        check_eq("t1_lag", 32'(pulse[0]), 32'd0);
        play("t1_pulse", 22, 5'b10001);
        bus_read("t1_status", ra(0, REG_STATUS), 32'h0001_010B, 1'b0);
        check_eq("t2_irq_hi", 32'(irq), 32'd1);
        bus_write("t2_w1c", ra(0, REG_STATUS), 32'h8, 1'b0);
        check_eq("t2_irq_lo", 32'(irq), 32'd0);

        // ---- test 3: infinite loops on ch1/ch2, stop ch1 ----
        bus_write("t3_ctrl1", ra(1, REG_CTRL), 32'h2, 1'b0);
        for (int i = 1; i <= 50; i++) exp_q.push_back((i % 2 == 1) ? 5'b00110 : 5'b00000);
        bus_write("t3_start", ra(0, REG_CMD), 32'h6, 1'b0);
        play("t3_run", 50, 5'b00110);
        for (int i = 52; i <= 71; i++) exp_q.push_back((i % 2 == 1) ? 5'b00110 : 5'b00010);
        bus_write("t3_stop", ra(2, REG_CMD), 32'h0002_0000, 1'b0);
        play("t3_after", 20, 5'b00110);

        // ---- test 4: start+stop together, start while busy ----
        bus_write("t4_stop0", ra(0, REG_CMD), 32'h0001_0000, 1'b0);
        bus_write("t4_both", ra(0, REG_CMD), 32'h0001_0001, 1'b0);
        bus_read("t4_status_idle", ra(0, REG_STATUS), 32'h0001_0100, 1'b0);
        bus_write("t4_start", ra(0, REG_CMD), 32'h1, 1'b0);
        idle(6);
        bus_write("t4_restart", ra(0, REG_CMD), 32'h1, 1'b0);
        bus_read("t4_status_busy", ra(0, REG_STATUS), 32'h0001_0206, 1'b0);

        // ---- test 5: busy write protection, table wrap, clamps, decode ----
        bus_write("t5_ctrl_busy", ra(0, REG_CTRL), 32'h3, 1'b1);
        bus_write("t5_dat_busy", ra(0, REG_PH_DAT), 32'hFFFF_FFFF, 1'b1);
        bus_write("t5_nph_busy", ra(0, REG_NPH), 32'd7, 1'b1);
        bus_read("t5_ctrl_rd", ra(0, REG_CTRL), 32'h0000_0200, 1'b0);
        bus_read("t5_idx_rd", ra(0, REG_PH_IDX), 32'd2, 1'b0);
        bus_read("t5_nph_rd", ra(0, REG_NPH), 32'd2, 1'b0);
        bus_write("t5_stop0", ra(0, REG_CMD), 32'h0001_0000, 1'b0);
        bus_write("t5_idx3", ra(3, REG_PH_IDX), 32'd0, 1'b0);
        for (int i = 0; i <= DEPTH; i++) begin
            bus_write("t5_fill", ra(3, REG_PH_DAT), {16'(i + 32), 16'(i + 1)}, 1'b0);
        end
        bus_read("t5_idx_wrap", ra(3, REG_PH_IDX), 32'd1, 1'b0);
        bus_write("t5_idx0", ra(3, REG_PH_IDX), 32'd0, 1'b0);
        bus_read("t5_entry0", ra(3, REG_PH_DAT), {16'(DEPTH + 32), 16'(DEPTH + 1)}, 1'b0);
        bus_write("t5_idx7", ra(3, REG_PH_IDX), 32'd7, 1'b0);
        bus_read("t5_entry7", ra(3, REG_PH_DAT), {16'd39, 16'd8}, 1'b0);
        bus_write("t5_idx9", ra(3, REG_PH_IDX), 32'd9, 1'b0);
        bus_read("t5_idx_mod", ra(3, REG_PH_IDX), 32'd1, 1'b0);
        bus_write("t5_nph0", ra(3, REG_NPH), 32'd0, 1'b0);
        bus_read("t5_nph_lo", ra(3, REG_NPH), 32'd1, 1'b0);
        bus_write("t5_nph100", ra(3, REG_NPH), 32'd100, 1'b0);
        bus_read("t5_nph_hi", ra(3, REG_NPH), 32'd8, 1'b0);
        bus_write("t5_nph5", ra(3, REG_NPH), 32'd5, 1'b0);
        bus_read("t5_nph_mid", ra(3, REG_NPH), 32'd5, 1'b0);
        bus_read("t5_unmapped_rd", ra(0, 4'h7), 32'd0, 1'b1);
        bus_write("t5_unmapped_wr", ra(1, 4'hF), 32'hFFFF_FFFF, 1'b1);
        bus_read("t5_cmd_rd", ra(2, REG_CMD), 32'd0, 1'b0);
        bus_read("t5_irqen_rd", ra(3, REG_IRQ_EN), 32'h1, 1'b0);

        // ---- test 6: zero lengths with invert, then reset mid-run ----
        bus_write("t6_ctrl1", ra(1, REG_CTRL), 32'h1, 1'b0);
        for (int i = 1; i <= 10; i++) exp_q.push_back((i % 2 == 1) ? 5'b00000 : 5'b00010);
        bus_write("t6_start", ra(1, REG_CMD), 32'h2, 1'b0);
        play("t6_toggle", 10, 5'b00010);
        rst_n = 1'b0;
        idle(1);
        check_eq("t6_rst_pulse", 32'(pulse), 32'd0);
        check_eq("t6_rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        bus_read("t6_status1", ra(1, REG_STATUS), 32'd0, 1'b0);
        bus_read("t6_ctrl1_rd", ra(1, REG_CTRL), 32'd0, 1'b0);
        bus_read("t6_tbl3", ra(3, REG_PH_DAT), 32'd0, 1'b0);
        bus_read("t6_nph3", ra(3, REG_NPH), 32'd1, 1'b0);
        bus_read("t6_irqen", ra(0, REG_IRQ_EN), 32'd0, 1'b0);
        idle(2);
        check_eq("t6_idle_pulse", 32'(pulse), 32'd0);

        check_eq("sb_pulse_left", 32'(exp_q.size()), 32'd0);
        check_eq("sb_read_left", 32'(rd_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
